pipelined_mem: RTL
==================

PIPELINED_MEM -- requirements
Module: pipelined_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter LINE_W, default 512, line data width; a multiple of ADDR_W and of 8.
REQ-003 SHALL have parameter DEPTH_LINES, default 256, number of stored lines; a power of two.
REQ-004 SHALL have parameter LATENCY, default 4, read latency in cycles; legal range 1..15.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, read queue depth; a power of two, at least 2.
REQ-006 SHALL have: clk  input  1  sole clock, rising edge.
REQ-007 SHALL have: rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have: req_valid  input  1  request present.
REQ-009 SHALL have: req_ready  output  1  request accepted when req_valid && req_ready.
REQ-010 SHALL have: req_write  input  1  1=write, 0=read.
REQ-011 SHALL have: req_addr  input  ADDR_W  byte address.
REQ-012 SHALL have: req_wdata  input  LINE_W  write line data.
REQ-013 SHALL have: resp_valid  output  1  read data present.
REQ-014 SHALL have: resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-015 SHALL have: resp_data  output  LINE_W  read line data.

Function
REQ-016 SHALL derive the line index as req_addr[OFF +: log2(DEPTH_LINES)], OFF=log2(LINE_W/8); upper bits ignored (aliasing).
REQ-017 SHALL keep one written-flag per line; a line with flag clear reads as the debug pattern {LINE_W/ADDR_W{line-aligned req_addr}} (offset bits zeroed).
REQ-018 SHALL commit an accepted write to storage and set its flag on the accept edge; writes produce no response and occupy no queue entry.
REQ-019 SHALL capture read data (storage or pattern) at the accept edge into a FIFO entry with a countdown initialised to LATENCY-1.
REQ-020 SHALL decrement every occupied entry's countdown each cycle, saturating at 0, regardless of resp_ready.
REQ-021 SHALL assert resp_valid registered when head entry occupied and its countdown is 0; read accepted at edge T gives resp_valid high at edge T+LATENCY with resp_ready high throughout.
REQ-022 SHALL return responses strictly in acceptance order; back-to-back reads yield back-to-back responses.
REQ-023 SHALL hold resp_valid and resp_data stable while resp_valid && !resp_ready.
REQ-024 SHALL drive req_ready = (occupancy < MAX_OUTSTANDING) for reads and writes alike; a same-cycle pop does not raise req_ready (no bypass).
REQ-025 SHALL support simultaneous accept and pop in one cycle, occupancy unchanged.
REQ-026 SHALL let a read observe a write accepted on an earlier edge; no two requests are accepted on one edge.
REQ-027 SHALL drive resp_data to all zeros when resp_valid is low.
REQ-028 SHALL not alter state on req_valid low or on rejected requests.

Reset
REQ-029 SHALL, on rst high, immediately clear queue, occupancy, countdowns and all written-flags; resp_valid=0, resp_data=0, req_ready=1 while rst high and after release.
REQ-030 SHALL drop outstanding reads on reset mid-operation; no response for them appears after release.
REQ-031 SHALL leave line storage uninitialised; cleared flags make post-reset reads return the debug pattern.

Verification
REQ-032 Defaults; reset; read 0x0000_1044 accepted edge 0 -> resp_valid high at edge 4 only, resp_data={16{32'h0000_1040}}.
REQ-033 Write 0x0000_0080 data D=all 0xA5 at edge 0; read 0x0000_0080 at edge 1 -> resp at edge 5 with D.
REQ-034 resp_ready=0; five back-to-back reads -> four accepted, req_ready low from edge 4; resp_ready=1 -> four in-order responses, req_ready high the cycle after first pop.
REQ-035 Response stalled 3 cycles with resp_ready=0 -> resp_valid and resp_data unchanged each cycle; single transfer on release.
REQ-036 Write 0x0000_0040 then reset with 2 reads outstanding -> no responses after release; read 0x0000_0040 returns {16{32'h0000_0040}}.
REQ-037 Write 0x0000_0040 data D, read 0x0000_4040 (alias, DEPTH_LINES=256) -> D returned.

Source files
------------

// File: rtl/pipelined_mem.sv
// rtl/pipelined_mem.sv - line memory with fixed read latency, in-order response FIFO and write-flag debug pattern
module pipelined_mem #(
    parameter int ADDR_W          = 32,
    parameter int LINE_W          = 512,
    parameter int DEPTH_LINES     = 256,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [LINE_W-1:0] resp_data
);
    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int REP   = LINE_W / ADDR_W;
    localparam logic [PTR_W:0]    MAX_OCC   = (PTR_W + 1)'(MAX_OUTSTANDING);
    localparam logic [3:0]        CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF;

    logic [LINE_W-1:0]      mem_q [DEPTH_LINES];
    logic [DEPTH_LINES-1:0] written_q, written_d;
    logic [LINE_W-1:0]      data_q [MAX_OUTSTANDING];
    logic [LINE_W-1:0]      data_d [MAX_OUTSTANDING];
    logic [3:0]             cnt_q  [MAX_OUTSTANDING];
    logic [3:0]             cnt_d  [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         occ_q, occ_d, remain;
    logic                   resp_valid_q, resp_valid_d;
    logic [LINE_W-1:0]      resp_data_q, resp_data_d;

    logic              accept, wr_en, push, pop;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] aligned;
    logic [LINE_W-1:0] rd_line;

    assign req_ready  = occ_q < MAX_OCC;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

    always_comb begin
        accept  = req_valid && req_ready;
        wr_en   = accept && req_write;
        push    = accept && !req_write;
        pop     = resp_valid_q && resp_ready;
        idx     = req_addr[OFF +: IDX_W];
        aligned = req_addr & LINE_MASK;
        rd_line = written_q[idx] ? mem_q[idx] : {REP{aligned}};

        written_d = written_q;
        if (wr_en) begin
            written_d[idx] = 1'b1;
        end

        // Countdowns of free slots also tick; a push overwrites its slot anyway.
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            data_d[i] = data_q[i];
            cnt_d[i]  = (cnt_q[i] != 4'd0) ? cnt_q[i] - 4'd1 : 4'd0;
        end
        if (push) begin
            data_d[wr_ptr_q] = rd_line;
            cnt_d[wr_ptr_q]  = CNT_INIT;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        occ_d    = occ_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

        // Next head judged on pre-edge state, so a fresh push is never visible this edge.
        remain       = occ_q - (PTR_W + 1)'(pop);
        resp_valid_d = (remain != '0) && (cnt_q[rd_ptr_d] == 4'd0);
        resp_data_d  = resp_valid_d ? data_q[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            written_q    <= written_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[idx] <= req_wdata;
        end
    end
endmodule
